// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the two-requester FP add/sub scheduler.
package fp_sched_pkg;
  localparam int PKG_TAG_W  = 5;
  localparam int PKG_CTRL_W = 5;

  // bit0 of the datapath control selects subtract
  localparam logic [PKG_CTRL_W-1:0] FP_ADD  = 5'b10000;
  localparam logic [PKG_CTRL_W-1:0] FP_SUB  = 5'b10001;
  localparam logic [31:0]           FP_ZERO = 32'h0;

  typedef struct packed {
    logic                 src;
    logic [PKG_TAG_W-1:0] tag;
    logic                 sub;
    logic [31:0]          a;
    logic [31:0]          b;
  } s1_t;

  typedef struct packed {
    logic                 src;
    logic [PKG_TAG_W-1:0] tag;
    logic [31:0]          result;
  } s2_t;
endpackage

// File: rtl/fp_addsub_dp.sv
// Single-precision add/sub core, round-to-nearest-even. Assumes a hidden 1
// on both operands; zero/cancellation cases are handled by the caller.
module fp_addsub_dp
  import fp_sched_pkg::*;
#(
  parameter int CTRL_W = PKG_CTRL_W
) (
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [31:0]       i_a,
  input  logic [31:0]       i_b,
  output logic [31:0]       o_res
);
  localparam logic [CTRL_W-1:0] OP_BASE = CTRL_W'(FP_ADD);

  logic              w_bs, w_swap, w_sl, w_ss, w_effsub, w_inc;
  logic [7:0]        w_el, w_es, w_d;
  logic [23:0]       w_ml, w_ms;
  logic [4:0]        w_sh, w_lz;
  logic [53:0]       w_ext;
  logic [26:0]       w_aln, w_norm;
  logic [27:0]       w_sum;
  logic [24:0]       w_rnd;
  logic signed [9:0] w_exp;

  always_comb begin
    w_bs   = i_b[31] ^ i_ctrl[0];
    w_swap = i_b[30:0] > i_a[30:0];
    {w_sl, w_el, w_ml} = w_swap ? {w_bs, i_b[30:23], 1'b1, i_b[22:0]}
                                : {i_a[31], i_a[30:23], 1'b1, i_a[22:0]};
    {w_ss, w_es, w_ms} = w_swap ? {i_a[31], i_a[30:23], 1'b1, i_a[22:0]}
                                : {w_bs, i_b[30:23], 1'b1, i_b[22:0]};
    w_effsub = w_sl ^ w_ss;
    // align the smaller operand with guard/round bits and a sticky LSB
    w_d   = w_el - w_es;
    w_sh  = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_ext = {w_ms, 3'b000, 27'b0} >> w_sh;
    w_aln = w_ext[53:27] | {26'b0, |w_ext[26:0]};
    w_sum = w_effsub ? ({1'b0, w_ml, 3'b000} - {1'b0, w_aln})
                     : ({1'b0, w_ml, 3'b000} + {1'b0, w_aln});
    w_lz = '0;
    for (int i = 0; i < 27; i++) if (w_sum[i]) w_lz = 5'(26 - i);
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], |w_sum[1:0]};
      w_exp  = $signed({2'b0, w_el}) + 10'sd1;
    end else begin
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = $signed({2'b0, w_el}) - $signed({5'b0, w_lz});
    end
    w_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[26:3]} + {24'b0, w_inc};
    if (w_rnd[24]) w_exp = w_exp + 10'sd1;

    if (i_ctrl[CTRL_W-1:1] != OP_BASE[CTRL_W-1:1]) o_res = FP_ZERO;
    else if (w_rnd[24:23] == 2'b00)                 o_res = FP_ZERO;
    else if (w_exp >= 10'sd255)                     o_res = {w_sl, 8'hFF, 23'b0};
    else if (w_exp <= 10'sd0)                       o_res = {w_sl, 31'b0};
    else                                            o_res = {w_sl, w_exp[7:0], w_rnd[22:0]};
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both requested
// and the grant was consumed (i_en).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);
  logic r_ptr;

  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                r_ptr <= 1'b0;
    else if (i_en && (&i_req)) r_ptr <= ~r_ptr;
  end
endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one FP add/sub datapath between two
// requesters through a 2-stage valid/ready pipeline.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int CTRL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sub,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sub,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_result,
  output logic             busy
);
  if (TAG_W != PKG_TAG_W) begin : g_tag_chk
    $error("TAG_W must equal fp_sched_pkg::PKG_TAG_W");
  end

  s1_t               r_s1;
  s2_t               r_s2;
  logic              r_s1_v, r_s2_v;
  logic              w_s1_adv, w_s2_adv, w_acc, w_bs;
  logic [1:0]        w_gnt;
  logic [7:0]        w_ea, w_eb;
  logic [CTRL_W-1:0] w_ctrl;
  logic [31:0]       w_dp_res, w_res;

  assign w_s2_adv = !r_s2_v | out_ready;
  assign w_s1_adv = !r_s1_v | w_s2_adv;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({req1_valid, req0_valid}),
    .i_en  (w_s1_adv & rst_n),
    .o_gnt (w_gnt)
  );

  assign req0_ready = rst_n & w_s1_adv & w_gnt[0];
  assign req1_ready = rst_n & w_s1_adv & w_gnt[1];
  assign w_acc      = req0_ready | req1_ready;

  assign w_ctrl = r_s1.sub ? CTRL_W'(FP_SUB) : CTRL_W'(FP_ADD);

  fp_addsub_dp #(.CTRL_W(CTRL_W)) u_dp (
    .i_ctrl (w_ctrl),
    .i_a    (r_s1.a),
    .i_b    (r_s1.b),
    .o_res  (w_dp_res)
  );

  // zero exponents (incl. denormals) and exact cancellation never reach the datapath result
  always_comb begin
    w_bs = r_s1.b[31] ^ r_s1.sub;
    w_ea = r_s1.a[30:23];
    w_eb = r_s1.b[30:23];
    w_res = w_dp_res;
    if (w_ea == 8'd0 && w_eb == 8'd0)                            w_res = {r_s1.a[31] & w_bs, 31'b0};
    else if (w_ea == 8'd0)                                       w_res = {w_bs, r_s1.b[30:0]};
    else if (w_eb == 8'd0)                                       w_res = r_s1.a;
    else if (r_s1.a[30:0] == r_s1.b[30:0] && r_s1.a[31] != w_bs) w_res = FP_ZERO;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_v <= w_acc;
      if (w_s2_adv) r_s2_v <= r_s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && w_acc)
      r_s1 <= w_gnt[1] ? '{1'b1, req1_tag, req1_sub, req1_a, req1_b}
                       : '{1'b0, req0_tag, req0_sub, req0_a, req0_b};
    if (w_s2_adv && r_s1_v)
      r_s2 <= '{r_s1.src, r_s1.tag, w_res};
  end

  assign out_valid  = r_s2_v;
  assign out_src    = r_s2.src;
  assign out_tag    = r_s2.tag;
  assign out_result = r_s2.result;
  assign busy       = r_s1_v | r_s2_v;
endmodule
